uart_tx_fifo: RTL and testbench

- Byte-oriented UART transmitter that drives the SOC's TXD pin, currently tied low; it is the transmit counterpart of the RXD input.
- The CPU or bench pushes bytes through a valid/ready write port into a small FIFO.
- A baud-timed shift state machine serialises each byte as 8N1: one start bit, 8 data bits LSB first, one stop bit, no parity.

---
 rtl/uart_tx_fifo.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte-wide UART transmitter (8N1, LSB first) fed through a
// small valid/ready FIFO.
//
// Ports:
//   CLK        system clock, all logic on the rising edge
//   RESET      asynchronous active-high reset; aborts any frame, empties FIFO
//   wr_valid   producer offers wr_data this cycle
//   wr_data    byte to transmit
//   wr_ready   FIFO can accept a byte (registered count != FIFO_DEPTH)
//   TXD        registered serial line, idle high
//   busy       FIFO non-empty or a frame in progress
//   fifo_count bytes queued, not counting the byte in the shifter
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        wr_valid,
  input  logic [7:0]                  wr_data,
  output logic                        wr_ready,
  output logic                        TXD,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]   FULL      = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   baud_cnt, baud_cnt_d;
  logic [2:0]         bit_idx, bit_idx_d;
  logic [7:0]         shift, shift_d;
  logic               txd_q, txd_d;

  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [PTR_W:0]     count;

  logic               push, pop;
  logic               has_data;
  logic               baud_last;

  assign wr_ready   = (count != FULL);
  assign push       = wr_valid && wr_ready;
  assign has_data   = (count != '0);
  assign baud_last  = (baud_cnt == BAUD_LAST);
  assign fifo_count = count;
  assign TXD        = txd_q;
  assign busy       = (state != IDLE) || has_data;

  // Storage is not reset; emptiness is tracked solely by the pointers/count.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      txd_q    <= 1'b1;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_cnt_d;
      bit_idx  <= bit_idx_d;
      shift    <= shift_d;
      txd_q    <= txd_d;
    end
  end

  always_comb begin
    state_d    = state;
    baud_cnt_d = baud_cnt;
    bit_idx_d  = bit_idx;
    shift_d    = shift;
    pop        = 1'b0;

    case (state)
      IDLE: begin
        if (has_data) begin
          pop        = 1'b1;
          shift_d    = mem[rd_ptr];
          baud_cnt_d = '0;
          state_d    = START;
        end
      end
      START: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          state_d    = DATA;
        end else begin
          baud_cnt_d = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          shift_d    = {1'b0, shift[7:1]};
          bit_idx_d  = bit_idx + 1'b1;
          if (bit_idx == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          baud_cnt_d = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          // Chain straight into the next start bit so queued bytes leave
          // with no idle gap.
          if (has_data) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // TXD is registered, so it is derived from the state being entered.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed/randomised bench for uart_tx_fifo with
// CLKS_PER_BIT=4, FIFO_DEPTH=4. A queue-based frame model predicts TXD,
// fifo_count, wr_ready and busy every cycle; a line decoder rebuilds the
// transmitted bytes from TXD for order checks.
module tb_uart_tx_fifo;

  localparam int BIT_CYC = 4;
  localparam int DEPTH   = 4;
  localparam int FRAME   = 10 * BIT_CYC;

  logic       CLK;
  logic       RESET;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       TXD;
  logic       busy;
  logic [2:0] fifo_count;

  uart_tx_fifo #(
    .CLKS_PER_BIT(BIT_CYC),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .TXD       (TXD),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: queued bytes, byte on the line, cycle offset in frame.
  logic [7:0] m_q[$];
  logic [7:0] m_cur;
  logic       m_active;
  int         m_pos;
  logic       last_acc;

  // Line decoder and accepted-byte log.
  logic [7:0] sent_q[$];
  logic [7:0] rx_q[$];
  logic       rx_on;
  int         rx_n;
  logic [7:0] rx_byte;

  int   busy_tally;
  logic saw_full;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_txd();
    int b;
    if (!m_active) return 1'b1;
    b = m_pos / BIT_CYC;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_cur[b-1];
  endfunction

  task automatic model_reset();
    m_q.delete();
    sent_q.delete();
    rx_q.delete();
    m_active = 1'b0;
    m_pos    = 0;
    m_cur    = '0;
    rx_on    = 1'b0;
    rx_n     = 0;
    last_acc = 1'b0;
  endtask

  task automatic step();
    logic acc;
    @(posedge CLK);
    // Acceptance depends only on the occupancy before this edge.
    acc = wr_valid && (m_q.size() != DEPTH);
    if (m_active) begin
      m_pos++;
      if (m_pos == FRAME) begin
        if (m_q.size() != 0) begin
          m_cur = m_q.pop_front();
          m_pos = 0;
        end else begin
          m_active = 1'b0;
        end
      end
    end else if (m_q.size() != 0) begin
      m_cur    = m_q.pop_front();
      m_pos    = 0;
      m_active = 1'b1;
    end
    if (acc) begin
      m_q.push_back(wr_data);
      sent_q.push_back(wr_data);
    end
    last_acc = acc;

    @(negedge CLK);
    chk("txd",   {7'd0, TXD},        {7'd0, exp_txd()});
    chk("count", {5'd0, fifo_count}, 8'(m_q.size()));
    chk("ready", {7'd0, wr_ready},   {7'd0, (m_q.size() != DEPTH)});
    chk("busy",  {7'd0, busy},       {7'd0, (m_active || m_q.size() != 0)});
    if (busy === 1'b1) busy_tally++;
    if (wr_ready === 1'b0) saw_full = 1'b1;

    if (rx_on) begin
      rx_n++;
      if (rx_n >= 6 && rx_n <= 34 && (rx_n % BIT_CYC) == 2)
        rx_byte[(rx_n - 6) / BIT_CYC] = TXD;
      if (rx_n == 38) begin
        chk("rx_stop", {7'd0, TXD}, 8'd1);
        rx_q.push_back(rx_byte);
        rx_on = 1'b0;
      end
    end else if (TXD === 1'b0) begin
      rx_on = 1'b1;
      rx_n  = 0;
    end
  endtask

  task automatic put(input logic [7:0] b);
    int n;
    n = 0;
    wr_valid = 1'b1;
    wr_data  = b;
    do begin
      step();
      n++;
    end while (!last_acc && n < 200);
    wr_valid = 1'b0;
    chk("put_accept", {7'd0, last_acc}, 8'd1);
  endtask

  task automatic wait_idle(input string tag);
    int   n;
    logic done;
    n = 0;
    while ((m_active || m_q.size() != 0) && n < 2000) begin
      step();
      n++;
    end
    done = !m_active && (m_q.size() == 0);
    chk(tag, {7'd0, done}, 8'd1);
    repeat (3) step();
  endtask

  task automatic check_rx(input string tag);
    logic [7:0] got;
    chk({tag, "_n"}, 8'(rx_q.size()), 8'(sent_q.size()));
    for (int i = 0; i < sent_q.size(); i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      chk(tag, got, sent_q[i]);
    end
    rx_q.delete();
    sent_q.delete();
  endtask

  initial begin
    logic [7:0] b;
    int         n;

    model_reset();
    busy_tally = 0;
    saw_full   = 1'b0;
    RESET      = 1'b1;
    wr_valid   = 1'b0;
    wr_data    = '0;

    // Reset state
    #12;
    chk("rst_txd",   {7'd0, TXD},        8'd1);
    chk("rst_count", {5'd0, fifo_count}, 8'd0);
    chk("rst_ready", {7'd0, wr_ready},   8'd1);
    chk("rst_busy",  {7'd0, busy},       8'd0);
    RESET = 1'b0;

    // Idle line
    repeat (1000) step();

    // Single byte: latency and busy length
    busy_tally = 0;
    put(8'h55);
    chk("lat_idle", {7'd0, TXD}, 8'd1);
    step();
    chk("lat_start", {7'd0, TXD}, 8'd0);
    repeat (58) step();
    chk("busy_len", 8'(busy_tally), 8'd41);
    check_rx("single");

    // Back-to-back
    put(8'hA5);
    put(8'h3C);
    wait_idle("b2b_idle");
    check_rx("b2b");

    // Full FIFO with a held producer
    saw_full = 1'b0;
    for (int i = 1; i <= 6; i++) put(8'(i));
    chk("full_seen", {7'd0, saw_full}, 8'd1);
    wait_idle("full_idle");
    check_rx("full");

    // Push coinciding with the stop-to-start pop at fifo_count=2
    for (int i = 0; i < 3; i++) put(8'($urandom));
    n = 0;
    while (!(m_active && m_pos == FRAME - 1) && n < 200) begin
      step();
      n++;
    end
    chk("pp_pre", {5'd0, fifo_count}, 8'd2);
    wr_valid = 1'b1;
    wr_data  = 8'($urandom);
    step();
    wr_valid = 1'b0;
    chk("pp_post", {5'd0, fifo_count}, 8'd2);
    wait_idle("pp_idle");
    check_rx("pushpop");

    // Randomised traffic; data is held while the FIFO refuses it
    for (int i = 0; i < 600; i++) begin
      if (!wr_valid || last_acc) begin
        wr_valid = ($urandom_range(0, 3) == 0);
        wr_data  = 8'($urandom);
      end
      step();
    end
    wr_valid = 1'b0;
    wait_idle("rand_idle");
    check_rx("random");

    // Asynchronous reset during data bit 3 of 0x00 with two bytes queued
    put(8'h00);
    put(8'($urandom));
    put(8'($urandom));
    n = 0;
    while (!(m_active && m_cur == 8'h00 && m_pos == 4 * BIT_CYC + 1) && n < 200) begin
      step();
      n++;
    end
    chk("mid_queued", {5'd0, fifo_count}, 8'd2);
    #2 RESET = 1'b1;
    #1;
    chk("mid_txd",   {7'd0, TXD},        8'd1);
    chk("mid_count", {5'd0, fifo_count}, 8'd0);
    chk("mid_busy",  {7'd0, busy},       8'd0);
    chk("mid_ready", {7'd0, wr_ready},   8'd1);
    model_reset();
    #1 RESET = 1'b0;
    repeat (100) step();
    chk("after_rst_rx", 8'(rx_q.size()), 8'd0);
    b = 8'hFF;
    put(b);
    wait_idle("ff_idle");
    check_rx("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
